axis_matvec_ws: RTL and testbench
=================================

// Module: axis_matvec_ws
// PURPOSE
//  Weight-stationary AXI-Stream signed matrix-vector multiplier, successor to the flat-bus MVM.
//  Loads K (R x C) row by row, keeps it resident, and reuses it for any number of x vectors.
//  Streams y one row per beat, so the UART front end no longer needs R*C*W_K-wide buses.
//  Sits between uart_rx word packers and uart_tx in the MVM UART system.
// PARAMETERS
//  R    8  matrix rows = y elements per vector
//  C    8  matrix columns = x elements per vector
//  W_X  8  signed x element width
//  W_K  8  signed K element width
//  W_Y  W_X+W_K+$clog2(C)  signed y width (derived localparam, not overridable)
// PORTS
//  clk              in   1           clock, rising edge
//  rstn             in   1           asynchronous active-low reset
//  s_axis_k_tvalid  in   1           K row beat valid
//  s_axis_k_tready  out  1           K row beat accepted when valid&ready
//  s_axis_k_tdata   in   C*W_K       one K row; element c at [W_K*(c+1)-1:W_K*c]
//  s_axis_k_tlast   in   1           marks row R-1
//  s_axis_x_tvalid  in   1           x vector valid
//  s_axis_x_tready  out  1           x vector accepted when valid&ready
//  s_axis_x_tdata   in   C*W_X       x vector; element c at [W_X*(c+1)-1:W_X*c]
//  m_axis_y_tvalid  out  1           y row result valid
//  m_axis_y_tready  in   1           downstream ready
//  m_axis_y_tdata   out  W_Y         y[r] = sum_c K[r][c]*x[c], signed
//  m_axis_y_tlast   out  1           high on row R-1 of each vector
//  m_axis_y_tuser   out  $clog2(R)   row index r of current beat
//  weights_valid    out  1           full K matrix resident
//  err              out  1           sticky framing error on K stream
// BEHAVIOUR
//  Reset: all outputs 0; state EMPTY; row counters 0; K storage contents don't-care.
//  States: EMPTY (no weights), LOAD (rows 1..R-1 pending), READY, COMPUTE.
//  EMPTY: k_tready=1, x_tready=0. Accepted K beat -> store row 0; tlast=1 and R>1 -> err, stay EMPTY.
//  LOAD: k_tready=1, x_tready=0; row counter increments per beat. tlast at row R-1 -> READY,
//   weights_valid=1. tlast early, or no tlast on row R-1 -> err=1, go EMPTY, weights_valid=0.
//   R=1: a single beat with tlast=1 goes EMPTY->READY directly.
//  READY: x_tready=1; k_tready = !s_axis_x_tvalid (x has priority on same-cycle valids).
//   Accepted x -> latch x, COMPUTE, row=0. Accepted K -> weights_valid=0, store row 0, LOAD.
//  COMPUTE: k_tready=0, x_tready=0. Each step computes row r with C parallel signed multipliers
//   and an adder tree, full-precision W_Y sum (no overflow possible), into the output register.
//   Step advances only when output register empty or being consumed (valid&ready this cycle).
//   No backpressure: x accepted at cycle T -> row r valid at T+1+r; one row per cycle.
//   After row R-1 is loaded into the output register, state -> READY (next x may be
//   accepted while row R-1 still awaits tready; its row 0 enters only once row R-1 drains).
//  Output: tdata/tlast/tuser held stable while tvalid&!tready; tvalid never drops without handshake.
//  err: set by framing error, cleared on next accepted K beat with row counter 0 that is not itself in error.
//  Reset mid-operation: immediate return to EMPTY, in-flight vector and weights discarded, tvalid=0.
// TESTING
//  Load K=identity(8x8), x={1,-2,3,-4,5,-6,7,-128} -> 8 beats y=x[r], tuser=0..7, tlast on beat 7.
//  K all 127, x all -128, tready=1 -> each y=-130048, rows at T+1..T+8, weights_valid stays 1.
//  Reuse: one K load, 3 back-to-back x vectors -> 24 y beats, no K re-send, correct sums each.
//  Toggle m_axis_y_tready 50% random -> no lost/duplicated rows, tdata stable while stalled.
//  K tlast on beat 5 -> err=1, weights_valid=0, x_tready=0; then valid 8-row load -> err=0, READY.
//  x and K valid same cycle in READY -> x accepted first, K accepted after vector completes.

Source files
------------

// File: rtl/axis_matvec_ws.sv
// Weight-stationary AXI-Stream signed matrix-vector multiplier: K is loaded row by row and kept
// resident, each accepted x vector streams out R result rows y[r] = sum_c K[r][c]*x[c].
module axis_matvec_ws #(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8,
    localparam int W_Y = W_X + W_K + $clog2(C),
    localparam int W_U = (R > 1) ? $clog2(R) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               s_axis_k_tvalid,
    output logic               s_axis_k_tready,
    input  logic [C*W_K-1:0]   s_axis_k_tdata,
    input  logic               s_axis_k_tlast,
    input  logic               s_axis_x_tvalid,
    output logic               s_axis_x_tready,
    input  logic [C*W_X-1:0]   s_axis_x_tdata,
    output logic               m_axis_y_tvalid,
    input  logic               m_axis_y_tready,
    output logic [W_Y-1:0]     m_axis_y_tdata,
    output logic               m_axis_y_tlast,
    output logic [W_U-1:0]     m_axis_y_tuser,
    output logic               weights_valid,
    output logic               err
);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_READY   = 2'd2;
    localparam logic [1:0] S_COMPUTE = 2'd3;

    localparam logic [W_U-1:0] LAST_ROW = W_U'(R - 1);

    // Full-precision dot product of one K row with x; W_Y is wide enough that no term can overflow.
    function automatic logic signed [W_Y-1:0] dot_row(input logic [C*W_K-1:0] k,
                                                      input logic [C*W_X-1:0] x);
        logic signed [W_Y-1:0] acc;
        logic signed [W_K-1:0] kc;
        logic signed [W_X-1:0] xc;
        acc = '0;
        for (int c = 0; c < C; c++) begin
            kc  = k[c*W_K +: W_K];
            xc  = x[c*W_X +: W_X];
            acc = acc + W_Y'(kc) * W_Y'(xc);
        end
        return acc;
    endfunction

    logic [1:0]            state_q, state_d;
    logic [W_U-1:0]        krow_q, krow_d;
    logic [W_U-1:0]        row_q, row_d;
    logic                  wv_q, wv_d;
    logic                  err_q, err_d;
    logic                  yv_q, yv_d;
    logic                  ylast_q, ylast_d;
    logic [W_U-1:0]        yuser_q, yuser_d;
    logic signed [W_Y-1:0] yd_q, yd_d;
    logic [C*W_K-1:0]      kmem_q [R];
    logic [C*W_X-1:0]      x_q;
    logic [W_U-1:0]        kaddr;
    logic                  k_fire, x_fire, step;

    // x wins over K when both are offered while the matrix is resident.
    assign s_axis_k_tready = rstn && ((state_q == S_EMPTY) || (state_q == S_LOAD) ||
                                      ((state_q == S_READY) && !s_axis_x_tvalid));
    assign s_axis_x_tready = rstn && (state_q == S_READY);

    assign k_fire = s_axis_k_tvalid && s_axis_k_tready;
    assign x_fire = s_axis_x_tvalid && s_axis_x_tready;
    assign step   = (state_q == S_COMPUTE) && (!yv_q || m_axis_y_tready);

    always_comb begin
        state_d = state_q;
        krow_d  = krow_q;
        row_d   = row_q;
        wv_d    = wv_q;
        err_d   = err_q;
        yv_d    = yv_q;
        ylast_d = ylast_q;
        yuser_d = yuser_q;
        yd_d    = yd_q;
        kaddr   = '0;

        if (yv_q && m_axis_y_tready) begin
            yv_d = 1'b0;
        end

        unique case (state_q)
            S_EMPTY, S_READY: begin
                if (x_fire) begin
                    state_d = S_COMPUTE;
                    row_d   = '0;
                end else if (k_fire) begin
                    wv_d = 1'b0;
                    if (s_axis_k_tlast != (R == 1)) begin
                        err_d   = 1'b1;
                        state_d = S_EMPTY;
                    end else if (R == 1) begin
                        err_d   = 1'b0;
                        wv_d    = 1'b1;
                        state_d = S_READY;
                    end else begin
                        err_d   = 1'b0;
                        krow_d  = W_U'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (k_fire) begin
                    kaddr = krow_q;
                    if (krow_q == LAST_ROW) begin
                        krow_d = '0;
                        if (s_axis_k_tlast) begin
                            wv_d    = 1'b1;
                            state_d = S_READY;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_EMPTY;
                        end
                    end else if (s_axis_k_tlast) begin
                        krow_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_EMPTY;
                    end else begin
                        krow_d = krow_q + W_U'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (step) begin
                    yv_d    = 1'b1;
                    yd_d    = dot_row(kmem_q[row_q], x_q);
                    yuser_d = row_q;
                    ylast_d = (row_q == LAST_ROW);
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = S_READY;
                    end else begin
                        row_d = row_q + W_U'(1);
                    end
                end
            end
        endcase
    end

    // Control and output register stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_EMPTY;
            krow_q  <= '0;
            row_q   <= '0;
            wv_q    <= 1'b0;
            err_q   <= 1'b0;
            yv_q    <= 1'b0;
            ylast_q <= 1'b0;
            yuser_q <= '0;
            yd_q    <= '0;
        end else begin
            state_q <= state_d;
            krow_q  <= krow_d;
            row_q   <= row_d;
            wv_q    <= wv_d;
            err_q   <= err_d;
            yv_q    <= yv_d;
            ylast_q <= ylast_d;
            yuser_q <= yuser_d;
            yd_q    <= yd_d;
        end
    end

    // Weight and vector storage
    always_ff @(posedge clk) begin
        if (k_fire) begin
            kmem_q[kaddr] <= s_axis_k_tdata;
        end
        if (x_fire) begin
            x_q <= s_axis_x_tdata;
        end
    end

    assign m_axis_y_tvalid = yv_q;
    assign m_axis_y_tdata  = yd_q;
    assign m_axis_y_tlast  = ylast_q;
    assign m_axis_y_tuser  = yuser_q;
    assign weights_valid   = wv_q;
    assign err             = err_q;

endmodule

// File: tb/tb_axis_matvec_ws.sv
// Directed bench for axis_matvec_ws (R=C=8, 8-bit operands): table-driven vectors plus
// hand-written sequences for latency, framing errors, x/K priority and mid-run reset.
module tb_axis_matvec_ws;

    typedef struct packed {
        logic [1:0]        kid;
        logic [7:0][7:0]   x;
        logic [7:0][18:0]  y;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        k_valid, k_ready, k_last;
    logic [63:0] k_data;
    logic        x_valid, x_ready;
    logic [63:0] x_data;
    logic        y_valid, y_ready, y_last;
    logic [18:0] y_data;
    logic [2:0]  y_user;
    logic        wv, err;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rmode = 0;
    int          beat_cyc [8];
    logic [22:0] exp_q [$];
    logic [22:0] mon_beat, held_beat;
    logic        hold_chk = 1'b0;

    axis_matvec_ws dut (
        .clk             (clk),
        .rstn            (rstn),
        .s_axis_k_tvalid (k_valid),
        .s_axis_k_tready (k_ready),
        .s_axis_k_tdata  (k_data),
        .s_axis_k_tlast  (k_last),
        .s_axis_x_tvalid (x_valid),
        .s_axis_x_tready (x_ready),
        .s_axis_x_tdata  (x_data),
        .m_axis_y_tvalid (y_valid),
        .m_axis_y_tready (y_ready),
        .m_axis_y_tdata  (y_data),
        .m_axis_y_tlast  (y_last),
        .m_axis_y_tuser  (y_user),
        .weights_valid   (wv),
        .err             (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mon_beat = {y_last, y_user, y_data};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
        end
    endtask

    // Output monitor: sampled mid-cycle, compares every handshake and checks stall stability.
    always @(negedge clk) begin
        if (rstn) begin
            if (hold_chk) check("y_hold", {y_valid, mon_beat}, {1'b1, held_beat});
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL y_extra: got beat 0x%0h want none", mon_beat);
                end else begin
                    check("y_beat", 64'(mon_beat), 64'(exp_q.pop_front()));
                end
                beat_cyc[y_user] = cyc;
            end
            hold_chk  = y_valid && !y_ready;
            held_beat = mon_beat;
        end else begin
            hold_chk = 1'b0;
        end
    end

    // Downstream ready: 0 = always ready, 1 = 50% random, 2 = held low.
    initial begin
        y_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       y_ready = 1'b1;
                1:       y_ready = 1'($urandom_range(0, 1));
                default: y_ready = 1'b0;
            endcase
        end
    end

    function automatic logic [7:0] kval(input int kid, input int r, input int c);
        case (kid)
            0:       return (r == c) ? 8'd1 : 8'd0;
            1:       return 8'd127;
            2:       return (c <= r) ? 8'd1 : 8'd0;
            default: return 8'h80;
        endcase
    endfunction

    function automatic logic [63:0] krow(input int kid, input int r);
        logic [63:0] d;
        for (int c = 0; c < 8; c++) d[c*8 +: 8] = kval(kid, r, c);
        return d;
    endfunction

    function automatic vec_t mk(input int kid, input int xs[8], input int ys[8]);
        vec_t v;
        v.kid = 2'(kid);
        for (int c = 0; c < 8; c++) begin
            v.x[c] = 8'(xs[c]);
            v.y[c] = 19'(ys[c]);
        end
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        for (int r = 0; r < 8; r++) exp_q.push_back({(r == 7), 3'(r), v.y[r]});
    endtask

    // All driving tasks start and end at posedge+2.
    task automatic send_k_beat(input logic [63:0] d, input logic l);
        int   n = 0;
        logic ok = 1'b0;
        k_valid = 1'b1;
        k_data  = d;
        k_last  = l;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = k_ready;
            @(posedge clk);
            #2;
            n++;
        end
        k_valid = 1'b0;
        k_last  = 1'b0;
        check("k_accept", 64'(ok), 64'(1));
    endtask

    task automatic load_k(input int kid, input int nbeats, input int lastidx);
        for (int r = 0; r < nbeats; r++) send_k_beat(krow(kid, r), (r == lastidx));
    endtask

    task automatic send_x(input logic [63:0] d, output int hs_edge);
        int   n = 0;
        logic ok = 1'b0;
        hs_edge = -1;
        x_valid = 1'b1;
        x_data  = d;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = x_ready;
            hs_edge = cyc + 1;
            @(posedge clk);
            #2;
            n++;
        end
        x_valid = 1'b0;
        check("x_accept", 64'(ok), 64'(1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        vec_t tbl [8];
        int   xs [8];
        int   ys [8];
        int   cur_kid, xe, ke, n;
        logic ok;

        xs = '{1, -2, 3, -4, 5, -6, 7, -128};    ys = '{1, -2, 3, -4, 5, -6, 7, -128};
        tbl[0] = mk(0, xs, ys);
        xs = '{8{-128}};                         ys = '{8{-130048}};
        tbl[1] = mk(1, xs, ys);
        xs = '{1, 2, 3, 4, 5, 6, 7, 8};          ys = '{8{4572}};
        tbl[2] = mk(1, xs, ys);
        xs = '{8{127}};                          ys = '{8{129032}};
        tbl[3] = mk(1, xs, ys);
        xs = '{1, -2, 3, -4, 5, -6, 7, -128};    ys = '{1, -1, 2, -2, 3, -3, 4, -124};
        tbl[4] = mk(2, xs, ys);
        xs = '{8{-128}};                         ys = '{-128, -256, -384, -512, -640, -768, -896, -1024};
        tbl[5] = mk(2, xs, ys);
        xs = '{8{-128}};                         ys = '{8{131072}};
        tbl[6] = mk(3, xs, ys);
        xs = '{8{127}};                          ys = '{8{-130048}};
        tbl[7] = mk(3, xs, ys);

        rstn = 1'b0; k_valid = 1'b0; k_last = 1'b0; k_data = '0;
        x_valid = 1'b0; x_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out", {k_ready, x_ready, y_valid, mon_beat, wv, err}, '0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        check("empty_ready", {k_ready, x_ready, wv, err}, 4'b1000);
        @(posedge clk);
        #2;

        // Table vectors, random downstream ready; same-K vectors go back to back.
        rmode   = 1;
        cur_kid = -1;
        for (int i = 0; i < 8; i++) begin
            if (int'(tbl[i].kid) != cur_kid) begin
                wait_drain();
                load_k(int'(tbl[i].kid), 8, 7);
                cur_kid = int'(tbl[i].kid);
                @(negedge clk);
                check("wv_load", {wv, err, x_ready}, 3'b101);
                @(posedge clk);
                #2;
            end
            push_exp(tbl[i]);
            send_x(tbl[i].x, xe);
        end
        wait_drain();

        // Latency with no backpressure: row r valid at T+1+r.
        rmode = 0;
        repeat (2) begin @(posedge clk); #2; end
        load_k(1, 8, 7);
        push_exp(tbl[1]);
        send_x(tbl[1].x, xe);
        wait_drain();
        for (int r = 0; r < 8; r++) check("latency", 64'(beat_cyc[r] - xe), 64'(r + 1));
        check("wv_kept", 64'(wv), 64'(1));

        // Early tlast on beat 5.
        load_k(1, 5, 4);
        @(negedge clk);
        check("err_early", {err, wv, x_ready}, 3'b100);
        @(posedge clk);
        #2;
        x_valid = 1'b1;
        x_data  = tbl[0].x;
        repeat (2) begin @(posedge clk); #2; end
        @(negedge clk);
        check("x_blocked", 64'(x_ready), 64'(0));
        @(posedge clk);
        #2;
        x_valid = 1'b0;
        load_k(0, 8, 7);
        @(negedge clk);
        check("err_clear", {err, wv, x_ready}, 3'b011);
        @(posedge clk);
        #2;

        // Missing tlast on row 7, then recovery and a vector through the new weights.
        load_k(0, 8, -1);
        @(negedge clk);
        check("err_no_last", {err, wv, x_ready}, 3'b100);
        @(posedge clk);
        #2;
        load_k(0, 8, 7);
        @(negedge clk);
        check("err_clear2", {err, wv, x_ready}, 3'b011);
        @(posedge clk);
        #2;
        push_exp(tbl[0]);
        send_x(tbl[0].x, xe);
        wait_drain();

        // Same-cycle x and K in READY: x first, K only once the vector has been computed.
        push_exp(tbl[0]);
        x_valid = 1'b1; x_data = tbl[0].x;
        k_valid = 1'b1; k_data = krow(1, 0); k_last = 1'b0;
        @(negedge clk);
        check("prio_rdy", {x_ready, k_ready}, 2'b10);
        xe = cyc + 1;
        @(posedge clk);
        #2;
        x_valid = 1'b0;
        ok = 1'b0;
        n  = 0;
        ke = -1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = k_ready;
            ke = cyc + 1;
            @(posedge clk);
            #2;
            n++;
        end
        k_valid = 1'b0;
        check("prio_k_after", 64'(ke - xe), 64'(9));
        for (int r = 1; r < 8; r++) send_k_beat(krow(1, r), (r == 7));
        wait_drain();
        check("prio_wv", 64'(wv), 64'(1));
        push_exp(tbl[2]);
        send_x(tbl[2].x, xe);
        wait_drain();

        // Reset while a result is stalled.
        rmode = 2;
        repeat (2) begin @(posedge clk); #2; end
        send_x(tbl[2].x, xe);
        repeat (4) begin @(posedge clk); #2; end
        @(negedge clk);
        check("stall_valid", {y_valid, y_user}, 4'b1000);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async", {y_valid, wv, x_ready, k_ready}, 4'b0000);
        exp_q.delete();
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_empty", {k_ready, x_ready, wv, err, y_valid}, 5'b10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
